up_counter_casc: RTL
====================

// Module: up_counter_casc
// PURPOSE
//   Cascaded modulo-N up counter. Counterpart to the 4-bit down counter: counts upward
//   through DIGITS digits, each modulo MODULUS (BCD-style with defaults).
//   Supports synchronous load, terminal-count look-ahead, a registered wrap pulse and a
//   sticky overflow flag. Used as an event/timebase counter beside the down counter.
// PARAMETERS
//   DIGITS   2   number of cascaded digit stages
//   DIGIT_W  4   bits per digit
//   MODULUS  10  digit count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**DIGIT_W
// PORTS
//   clk       in   1                single clock, rising edge
//   rst       in   1                synchronous, active-high reset
//   en        in   1                count enable: increment by one when high
//   load      in   1                synchronous load of load_val
//   load_val  in   DIGITS*DIGIT_W   value to load; digit 0 is the LSBs
//   ovf_clr   in   1                clears the sticky ovf flag
//   q         out  DIGITS*DIGIT_W   current count; digit 0 is the LSBs
//   tc        out  1                combinational: en && every digit == MODULUS-1
//   wrap      out  1                registered one-cycle pulse, high in the cycle after q returns to 0
//   ovf       out  1                sticky overflow flag
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): q=0, wrap=0, ovf=0. Reset overrides every other input.
//   - Priority at each edge: rst > load > en. When none is active, q holds.
//   - load: each digit takes its load_val digit. Any digit >= MODULUS loads as 0 instead.
//     No other digit is changed by this correction, and no carry is generated.
//   - en (without load): digit 0 increments. Digit k increments only when en=1 and
//     digits 0..k-1 all equal MODULUS-1. A digit at MODULUS-1 that increments wraps to 0.
//   - Latency: q updates one edge after en or load is sampled.
//   - tc: purely combinational from en and q; it has no dependence on load.
//   - Full wrap: an edge with en=1, load=0, rst=0 and tc=1 sets q=0.
//     - On that edge the wrap register loads 1, so wrap=1 for exactly the next cycle;
//       otherwise wrap loads 0.
//     - On that edge ovf is set.
//   - load=1 while tc=1: the load wins; no wrap pulse and no ovf set.
//   - ovf_clr=1 clears ovf at the edge. If a wrap happens on the same edge, the set wins
//     and ovf stays 1.
//   - Consecutive wraps (MODULUS**DIGITS enables apart) each produce a separate wrap pulse.
//   - rst mid-count: q=0 at the next edge. Any pending wrap is dropped (wrap=0).
//   - Arithmetic: no addition across the full DIGITS*DIGIT_W width. Each digit compares
//     against MODULUS-1 and increments within DIGIT_W bits.
// STRUCTURE
//   - Shared package holds:
//     - default DIGITS, DIGIT_W and MODULUS constants;
//     - a digit_t typedef (logic [DIGIT_W-1:0]);
//     - a function that saturates an out-of-range digit to 0.
//   - Sub-module up_mod_digit holds one digit:
//     - inputs clk, rst, inc, load, d;
//     - outputs q and at_max (q==MODULUS-1).
//   - The top level instantiates DIGITS copies in a generate loop.
//     - Digit k's inc is en && at_max of digits 0..k-1 (AND chain).
//     - tc = en && at_max of every digit.
//     - wrap and ovf registers live in the top level.
// TESTING (DIGITS=2, DIGIT_W=4, MODULUS=10)
//   1. Reset, then rst=0 with en=0 for 3 cycles -> q=8'h00, wrap=0, ovf=0 and q holds.
//   2. en=1 for 99 edges -> q=8'h99 with tc=1. Edge 100 -> q=8'h00, wrap=1 for one cycle, ovf=1.
//   3. load=1 with load_val=8'h57 -> q=8'h57 next edge. Then en=1 for 3 edges -> q=8'h60
//      (digit carry checked).
//   4. load_val=8'h3C -> q=8'h30. load_val=8'hF9 -> q=8'h09. No wrap, ovf unchanged.
//   5. q=8'h99 with en=1, load=1 and load_val=8'h12 -> q=8'h12, wrap=0, ovf not set.
//      Then q=8'h99 with en=1 and ovf_clr=1 -> q=8'h00 and ovf remains 1.
//   6. Count to 8'h45, then assert rst for 1 cycle with en=1 -> q=8'h00 next edge, wrap=0,
//      ovf=0. Counting resumes from 8'h00 after rst drops.

Source files
------------

// File: rtl/up_counter_casc_pkg.sv
// Shared definitions for the cascaded modulo-N up counter: default geometry,
// the per-digit type and the load-value range correction helper.
package up_counter_casc_pkg;

  localparam int DIGITS_DEF  = 2;
  localparam int DIGIT_W_DEF = 4;
  localparam int MODULUS_DEF = 10;

  typedef logic [DIGIT_W_DEF-1:0] digit_t;

  // A loaded digit outside 0..modulus-1 is replaced by 0; in-range values pass through.
  function automatic logic [31:0] sat_digit(input logic [31:0] value, input int unsigned modulus);
    return (value >= modulus) ? 32'd0 : value;
  endfunction

endpackage

// File: rtl/up_mod_digit.sv
// One modulo-MODULUS digit stage: synchronous reset, load with range correction,
// and increment-with-wrap when its cascade input says every lower digit is at max.
module up_mod_digit
  import up_counter_casc_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int MODULUS = MODULUS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max
);

  localparam logic [DIGIT_W-1:0] MaxVal = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] d_sat;

  assign d_sat  = DIGIT_W'(sat_digit(32'(d), MODULUS));
  assign at_max = (q == MaxVal);

  // Digit register: reset beats load, load beats increment; the top digit value wraps to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d_sat;
    end else if (inc) begin
      q <= at_max ? '0 : q + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/up_counter_casc.sv
// Cascaded modulo-N up counter built from DIGITS digit stages. Carries ripple
// through an AND chain of per-digit at_max flags, so no full-width adder exists.
// Also provides terminal-count look-ahead, a registered wrap pulse and a sticky
// overflow flag.
module up_counter_casc
  import up_counter_casc_pkg::*;
#(
  parameter int DIGITS  = DIGITS_DEF,
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int MODULUS = MODULUS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_val,
  input  logic                      ovf_clr,
  output logic [DIGITS*DIGIT_W-1:0] q,
  output logic                      tc,
  output logic                      wrap,
  output logic                      ovf
);

  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] at_max;
  logic              full_wrap;

  assign carry[0] = en;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign carry[k+1] = carry[k] & at_max[k];

    up_mod_digit #(
      .DIGIT_W (DIGIT_W),
      .MODULUS (MODULUS)
    ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .inc    (carry[k]),
      .load   (load),
      .d      (load_val[k*DIGIT_W +: DIGIT_W]),
      .q      (q[k*DIGIT_W +: DIGIT_W]),
      .at_max (at_max[k])
    );
  end

  // tc looks only at en and the digits; load suppresses the wrap side effects instead.
  assign tc        = carry[DIGITS];
  assign full_wrap = tc & ~load;

  // Wrap pulse: high for the single cycle following the edge where q rolls over to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= full_wrap;
    end
  end

  // Sticky overflow: a rollover sets it and wins over a clear on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (full_wrap) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule
